// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper controller blocks: delay-counter state
// encoding and default sizing of the delay datapath.
package stepper_pkg;

  // Width of a delay value as it leaves the register file read port.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Clock cycles per delay unit: 1 ms per unit with a 50 MHz system clock.
  localparam int DEFAULT_TICK_DIV = 50000;

  // Delay counter state encoding, kept here so the controller FSM and any
  // status readback decode the same values.
  localparam logic [1:0] DLY_IDLE    = 2'd0;
  localparam logic [1:0] DLY_COUNT   = 2'd1;
  localparam logic [1:0] DLY_EXPIRED = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = DLY_IDLE,
    ST_COUNT   = DLY_COUNT,
    ST_EXPIRED = DLY_EXPIRED
  } dly_state_t;

  // True for the only state in which the prescaler is allowed to run.
  function automatic logic is_counting(input dly_state_t s);
    return (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into delay-unit ticks. The counter only moves
// while enabled, so a dropped enable holds the partial unit in place rather
// than losing it. A clear restarts the unit from zero and beats enable.
module tick_prescaler #(
  parameter int TICK_DIV       = 4,
  parameter int PRESCALE_WIDTH = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PRESCALE_WIDTH-1:0] LAST = PRESCALE_WIDTH'(TICK_DIV - 1);

  logic [PRESCALE_WIDTH-1:0] count;

  // A tick marks the last cycle of a unit; a pending clear suppresses it so
  // a restart never inherits a half-finished unit.
  assign tick = enable && !clear && (count == LAST);

  // Advance on enable, wrap after the last cycle of a unit, freeze otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/step_delay_counter.sv
// Programmable delay timer for the stepper controller. The control FSM arms
// it with a one-cycle start pulse and holds enable while waiting; delay_done
// rises after delay_value units of TICK_DIV enabled cycles and stays high
// until the next start or reset, so the FSM may sample it at leisure.
module step_delay_counter #(
  parameter int DATA_WIDTH     = stepper_pkg::DEFAULT_DATA_WIDTH,
  parameter int TICK_DIV       = stepper_pkg::DEFAULT_TICK_DIV,
  parameter int PRESCALE_WIDTH = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_delay_counter,
  input  logic                  enable_delay_counter,
  input  logic [DATA_WIDTH-1:0] delay_value,
  output logic                  delay_done,
  output logic                  delay_busy,
  output logic [DATA_WIDTH-1:0] delay_remaining
);

  import stepper_pkg::*;

  dly_state_t            state;
  dly_state_t            state_next;
  logic [DATA_WIDTH-1:0] remaining_next;
  logic                  done_next;
  logic                  tick;
  logic                  prescale_enable;

  // The prescaler only sees enable while a delay is actually running, so
  // enable pulses in IDLE or EXPIRED cannot pre-load a partial unit.
  assign prescale_enable = enable_delay_counter && is_counting(state);

  tick_prescaler #(
    .TICK_DIV      (TICK_DIV),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (start_delay_counter),
    .enable(prescale_enable),
    .tick  (tick)
  );

  // Next-state logic: a start from any state reloads the delay, otherwise
  // each tick consumes one unit and the final unit moves to EXPIRED.
  always_comb begin
    state_next     = state;
    remaining_next = delay_remaining;
    done_next      = delay_done;
    if (start_delay_counter) begin
      remaining_next = delay_value;
      if (delay_value == '0) begin
        state_next = ST_EXPIRED;
        done_next  = 1'b1;
      end else begin
        state_next = ST_COUNT;
        done_next  = 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done_next = 1'b0;
        end
        ST_COUNT: begin
          if (tick) begin
            if (delay_remaining <= DATA_WIDTH'(1)) begin
              remaining_next = '0;
              done_next      = 1'b1;
              state_next     = ST_EXPIRED;
            end else begin
              remaining_next = delay_remaining - DATA_WIDTH'(1);
            end
          end
        end
        ST_EXPIRED: begin
          done_next = 1'b1;
        end
        default: begin
          state_next     = ST_IDLE;
          remaining_next = '0;
          done_next      = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; busy is registered from the next state so it
  // lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      delay_remaining <= '0;
      delay_done      <= 1'b0;
      delay_busy      <= 1'b0;
    end else begin
      state           <= state_next;
      delay_remaining <= remaining_next;
      delay_done      <= done_next;
      delay_busy      <= is_counting(state_next);
    end
  end

endmodule

// File: doc/step_delay_counter.md
Name: step_delay_counter

Overview:
- Programmable delay timer that serves the stepper controller FSM.
- The FSM pulses start_delay_counter to arm a delay and holds enable_delay_counter high while it waits.
- The block returns delay_done, which paces step pulses (MOVR/MOVRHS) and PAUSE.
- Delay length = delay_value x TICK_DIV clock cycles; delay_value comes from the register-file read port.

Parameters:
- DATA_WIDTH, 8, width of delay_value and the remaining-count register
- TICK_DIV, 50000, clk cycles per delay unit (1 ms at 50 MHz); must be >= 2
- PRESCALE_WIDTH, $clog2(TICK_DIV), prescaler counter width (derived; not overridden)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_delay_counter  input  1  one-cycle arm pulse from the control FSM
- enable_delay_counter  input  1  count-enable level from the control FSM
- delay_value  input  DATA_WIDTH  delay in units, sampled on start
- delay_done  output  1  delay expired; registered, sticky until next start or reset
- delay_busy  output  1  armed and not yet expired
- delay_remaining  output  DATA_WIDTH  units still to elapse (debug/status)

Behaviour:
- One clock; reset is synchronous and active-high; one clock domain, all outputs registered.
- Reset: state=IDLE, delay_done=0, delay_busy=0, delay_remaining=0, prescaler=0. Reset wins over every other input, including mid-count.
- States: IDLE, COUNT, EXPIRED.
- start (any state): delay_remaining<=delay_value, prescaler<=0, delay_done<=0.
  - Next state is COUNT if delay_value!=0.
  - If delay_value==0, next state is EXPIRED and delay_done<=1.
- COUNT: prescaler advances only while enable=1. Enable=0 freezes prescaler and remaining (a hold, not a clear).
- Tick = enable && prescaler==TICK_DIV-1. On a tick the prescaler wraps to 0 and remaining decrements.
- Expiry: a tick with remaining==1 sets remaining<=0, delay_done<=1, state<=EXPIRED.
- Latency: start captured at edge t, enable continuously high from cycle t+1, N>=1. Then delay_done is first high in cycle t+N*TICK_DIV, i.e. exactly N*TICK_DIV enabled cycles after arming.
- EXPIRED: delay_done held at 1 and enable ignored until the next start or reset. This lets the FSM sample done on any cycle and leave.
- delay_busy = (state==COUNT).
- start coincident with enable: start wins; that cycle does not count toward the new delay.
- start during COUNT: restarts with the new delay_value; the old delay is discarded and no done pulse is produced for it.
- enable in IDLE: no effect; done stays 0.
- Remaining never underflows and the prescaler never exceeds TICK_DIV-1.
- Max delay: (2^DATA_WIDTH-1)*TICK_DIV cycles.

Decomposition:
- Shared package stepper_pkg holds:
  - state encoding localparams DLY_IDLE, DLY_COUNT, DLY_EXPIRED (2-bit)
  - DATA_WIDTH
  - default TICK_DIV
- Sub-module tick_prescaler:
  - inputs clk, reset, clear, enable
  - output tick
  - parameter TICK_DIV
  - holds the prescaler counter; clear overrides enable.
- The top level holds the FSM and the remaining-count register.

Test Plan (bench uses TICK_DIV=4):
- Reset 2 cycles, delay_value=3, start at cycle 0, enable high from cycle 1 -> delay_done=0 through cycle 11, =1 at cycle 12 and held; delay_remaining steps 3,2,1,0 at cycles 4,8,12; busy=1 cycles 1-11.
- delay_value=2, start, enable high 3 cycles, low 5, high again -> done appears 5 cycles later than uninterrupted (cycle 13); remaining frozen at 2 during the gap.
- delay_value=0, start -> done=1 the cycle after start, busy never high; enable pulses leave done=1.
- delay_value=5, start, run 6 enabled cycles, then start with delay_value=1 -> done=0 until 4 enabled cycles after the restart, then 1; no early done.
- delay_value=4, mid-count reset=1 for 1 cycle -> next cycle done=0, busy=0, remaining=0; subsequent enable alone never asserts done.
- start and enable high in the same cycle, delay_value=1 -> done at 4 enabled cycles after that cycle, not 3.
